// File: rtl/scan_fsm_fault_inject_pkg.sv
// ----------------------------------------------------------------------------
// fsm_fi_pkg
// Shared types and constants for the scan-chained sequence-detector FSM with
// runtime fault injection.
//   FSM_FI_N_BITS_DEFAULT : default number of state flops / scan length
//   fault_mode_e          : fault kind applied to the selected state bit
//   apply_fault()         : faulted value of one state bit for a given mode
// ----------------------------------------------------------------------------
package fsm_fi_pkg;

    localparam int FSM_FI_N_BITS_DEFAULT = 3;

    typedef enum logic [1:0] {
        FM_NONE = 2'b00,
        FM_SA0  = 2'b01,
        FM_SA1  = 2'b10,
        FM_FLIP = 2'b11
    } fault_mode_e;

    // Value seen by the next-state logic for a bit that is the fault site.
    function automatic logic apply_fault(input logic bit_in, input fault_mode_e mode);
        logic res;
        case (mode)
            FM_SA0:  res = 1'b0;
            FM_SA1:  res = 1'b1;
            FM_FLIP: res = ~bit_in;
            default: res = bit_in;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scan_fsm_fault_inject_dff.sv
// ----------------------------------------------------------------------------
// scan_dff
// Muxed-D scan flop: captures d in functional mode, scan_in in shift mode.
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset (q -> 0)
//   scan_in     : serial scan data
//   scan_enable : 1 = shift (take scan_in), 0 = capture (take d)
//   d           : functional next-state data
//   q           : registered state bit
// ----------------------------------------------------------------------------
module scan_dff (
    input  logic clk,
    input  logic rst,
    input  logic scan_in,
    input  logic scan_enable,
    input  logic d,
    output logic q
);

    // State flop with scan mux in front of the D input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (scan_enable) begin
            q <= scan_in;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/scan_fsm_fault_inject.sv
// ----------------------------------------------------------------------------
// scan_fsm_fault_inject
// N-flop scan-chained sequence detector with a programmable fault site.
// The state flops form a scan chain q[0] -> q[N_BITS-1]. In capture mode the
// next state is computed from the faulted view qf, so an injected fault
// propagates into the machine exactly like a real defect; the shift path
// always uses the true flop values so scan data is never corrupted.
//
// Build option: FAULT_INJECT_EN
//   defined   : fault register, qf mux and fault_active are built
//   undefined : qf = q, fault_active = 0, fault_* inputs are ignored
//
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   scan_in      : serial scan data into flop 0
//   scan_enable  : 1 = shift, 0 = functional capture
//   inp          : functional FSM input
//   fault_load   : strobe, registers fault_sel/fault_mode this cycle
//   fault_sel    : target state-bit index
//   fault_mode   : 00 none, 01 stuck-at-0, 10 stuck-at-1, 11 one-shot flip
//   out          : faulted view of q[N_BITS-1]
//   scan_out     : true q[N_BITS-1], scan chain tail
//   fault_active : 1 while the registered fault mode is not "none"
// ----------------------------------------------------------------------------
module scan_fsm_fault_inject
    import fsm_fi_pkg::*;
#(
    parameter int N_BITS = FSM_FI_N_BITS_DEFAULT,
    parameter int SEL_W  = $clog2(N_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_in,
    input  logic             scan_enable,
    input  logic             inp,
    input  logic             fault_load,
    input  logic [SEL_W-1:0] fault_sel,
    input  logic [1:0]       fault_mode,
    output logic             out,
    output logic             scan_out,
    output logic             fault_active
);

    logic [N_BITS-1:0] q_s;    // true flop values
    logic [N_BITS-1:0] qf_s;   // faulted view used by the next-state logic
    logic [N_BITS-1:0] d_s;    // functional next state

`ifdef FAULT_INJECT_EN

    // One extra bit so that N_BITS itself is representable for the range check.
    localparam logic [SEL_W:0] N_BITS_W = (SEL_W + 1)'(N_BITS);

    logic [SEL_W-1:0] fault_sel_r;
    fault_mode_e      fault_mode_r;
    logic             sel_in_range_s;

    assign sel_in_range_s = ({1'b0, fault_sel} < N_BITS_W);

    // Fault register: a load always wins; otherwise a pending flip is consumed
    // by the first functional capture edge and stays armed across shifts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_sel_r  <= {SEL_W{1'b0}};
            fault_mode_r <= FM_NONE;
        end else if (fault_load) begin
            fault_sel_r  <= fault_sel;
            fault_mode_r <= sel_in_range_s ? fault_mode_e'(fault_mode) : FM_NONE;
        end else if (!scan_enable && (fault_mode_r == FM_FLIP)) begin
            fault_sel_r  <= fault_sel_r;
            fault_mode_r <= FM_NONE;
        end else begin
            fault_sel_r  <= fault_sel_r;
            fault_mode_r <= fault_mode_r;
        end
    end

    // Faulted view: only the selected bit is altered, zero latency.
    always_comb begin
        qf_s = q_s;
        for (int i = 0; i < N_BITS; i++) begin
            if (fault_sel_r == SEL_W'(i)) begin
                qf_s[i] = apply_fault(q_s[i], fault_mode_r);
            end else begin
                qf_s[i] = q_s[i];
            end
        end
    end

    assign fault_active = (fault_mode_r != FM_NONE);

`else

    // Fault controls are accepted on the ports but have no effect here.
    logic unused_fault_s;
    assign unused_fault_s = ^{fault_load, fault_sel, fault_mode};

    assign qf_s         = q_s;
    assign fault_active = 1'b0;

`endif

    // Sequence-detector next state, driven from the faulted view.
    always_comb begin
        d_s    = {N_BITS{1'b0}};
        d_s[0] = (qf_s[N_BITS-2] & ~inp) | (qf_s[N_BITS-1] & inp);
        for (int i = 1; i < N_BITS; i++) begin
            d_s[i] = qf_s[i-1] & inp;
        end
    end

    // State flops chained through their scan inputs; flop 0 is the chain head.
    genvar g;
    generate
        for (g = 0; g < N_BITS; g++) begin : g_chain
            logic chain_in_s;
            if (g == 0) begin : g_head
                assign chain_in_s = scan_in;
            end else begin : g_link
                assign chain_in_s = q_s[g-1];
            end

            scan_dff u_dff (
                .clk         (clk),
                .rst         (rst),
                .scan_in     (chain_in_s),
                .scan_enable (scan_enable),
                .d           (d_s[g]),
                .q           (q_s[g])
            );
        end
    endgenerate

    assign out      = qf_s[N_BITS-1];
    assign scan_out = q_s[N_BITS-1];

endmodule

// File: tb/tb_scan_fsm_fault_inject.sv
module tb_scan_fsm_fault_inject;

    localparam int N = 3;
`ifdef FAULT_INJECT_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_in = 1'b0;
    logic       scan_enable = 1'b0;
    logic       inp = 1'b0;
    logic       fault_load = 1'b0;
    logic [1:0] fault_sel = 2'b00;
    logic [1:0] fault_mode = 2'b00;
    logic       out;
    logic       scan_out;
    logic       fault_active;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: state bits plus the programmed fault site and kind.
    bit mq [N];
    int msel;
    int mmode;   // 0 none, 1 stuck-0, 2 stuck-1, 3 one-shot flip

    scan_fsm_fault_inject #(.N_BITS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_in      (scan_in),
        .scan_enable  (scan_enable),
        .inp          (inp),
        .fault_load   (fault_load),
        .fault_sel    (fault_sel),
        .fault_mode   (fault_mode),
        .out          (out),
        .scan_out     (scan_out),
        .fault_active (fault_active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Value of state bit i as the machine "sees" it under the current fault.
    function automatic bit model_view(int i);
        if (FEN && mmode != 0 && msel == i) begin
            if (mmode == 1) return 1'b0;
            if (mmode == 2) return 1'b1;
            return ~mq[i];
        end
        return mq[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i] = 1'b0;
        msel  = 0;
        mmode = 0;
    endtask

    task automatic model_clock(input bit se, input bit si, input bit in_b,
                               input bit fl, input int fs, input int fm);
        bit nq [N];
        if (se) begin
            nq[0] = si;
            for (int i = 1; i < N; i++) nq[i] = mq[i-1];
        end else begin
            nq[0] = in_b ? model_view(N-1) : model_view(N-2);
            for (int i = 1; i < N; i++) nq[i] = in_b & model_view(i-1);
        end
        if (fl) begin
            msel  = fs;
            mmode = (fs < N) ? fm : 0;
        end else if (!se && mmode == 3) begin
            mmode = 0;
        end
        mq = nq;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".out"}, out, model_view(N-1));
        check_eq({tag, ".scan_out"}, scan_out, mq[N-1]);
        check_eq({tag, ".fault_active"}, fault_active, (FEN && mmode != 0));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic cycle(input bit se, input bit si, input bit in_b,
                         input bit fl, input logic [1:0] fs, input logic [1:0] fm);
        scan_enable = se;
        scan_in     = si;
        inp         = in_b;
        fault_load  = fl;
        fault_sel   = fs;
        fault_mode  = fm;
        @(posedge clk);
        #1;
        model_clock(se, si, in_b, fl, int'(fs), int'(fm));
        fault_load = 1'b0;
        check_outputs("cyc");
    endtask

    task automatic apply_reset();
        scan_enable = 1'($urandom_range(0, 1));
        scan_in     = 1'($urandom_range(0, 1));
        inp         = 1'($urandom_range(0, 1));
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst.out", out, 1'b0);
        check_eq("rst.scan_out", scan_out, 1'b0);
        check_eq("rst.fault_active", fault_active, 1'b0);
        rst = 1'b1;
    endtask

    // Shift v in MSB first so that afterwards q{2,1,0} == v.
    task automatic scan_load(input logic [N-1:0] v);
        for (int k = N - 1; k >= 0; k--) cycle(1'b1, v[k], 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    // Shift the state out through scan_out; returns it as q{2,1,0}.
    task automatic scan_read(output logic [N-1:0] v);
        for (int k = N - 1; k >= 0; k--) begin
            v[k] = scan_out;
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        end
    endtask

    logic [N-1:0] rd;

    initial begin
        model_reset();
        #1;
        apply_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Idle capture after reset keeps the machine at zero.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        scan_read(rd);
        check_eq("idle_q", rd, 3'b000);

        // Scan shift 1,0,0 then observe it serially.
        scan_load(3'b100);
        check_eq("shift.out", out, 1'b1);
        check_eq("shift.scan_out", scan_out, 1'b1);
        scan_read(rd);
        check_eq("shift_seq", rd, 3'b100);

        // Fault-free captures.
        scan_load(3'b010);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        scan_read(rd);
        check_eq("good_inp0", rd, 3'b001);
        scan_load(3'b010);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        scan_read(rd);
        check_eq("good_inp1", rd, 3'b100);

        // Stuck-at-0 on bit 1.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'b01);
        scan_load(3'b010);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        check_eq("sa0.active", fault_active, FEN);
        scan_read(rd);
        check_eq("sa0_inp0", rd, FEN ? 3'b000 : 3'b001);
        scan_load(3'b010);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        scan_read(rd);
        check_eq("sa0_inp1", rd, FEN ? 3'b000 : 3'b100);
        check_eq("sa0.persist", fault_active, FEN);

        // Stuck-at-1 on bit 2.
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'b10);
        check_eq("sa1.out", out, FEN);
        check_eq("sa1.scan_out", scan_out, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        scan_read(rd);
        check_eq("sa1_inp1", rd, FEN ? 3'b001 : 3'b000);

        // One-shot flip on bit 0 stays armed through shifts.
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'b11);
        scan_load(3'b001);
        check_eq("flip.pending", fault_active, FEN);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        check_eq("flip.consumed", fault_active, 1'b0);
        scan_read(rd);
        check_eq("flip_inp1", rd, FEN ? 3'b000 : 3'b010);

        // Out-of-range site is rejected as no fault.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'b01);
        check_eq("sel_oob.active", fault_active, 1'b0);

        // Load and flip consumption on the same capture edge: load wins.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'b11);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'b11);
        check_eq("load_wins.active", fault_active, FEN);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                apply_reset();
            end else begin
                cycle(($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0),
                      2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_fsm_fault_inject.md
Name: scan_fsm_fault_inject

Overview:
- Parametrised N-flop scan-chained sequence-detector FSM with runtime-programmable fault injection at any state bit.
- Supports stuck-at-0, stuck-at-1 and single-capture bit-flip faults.
- Generalises the fixed 3-flop design with its hard-wired stuck-at fault. Used as the device-under-test for ATPG pattern generation and fault-coverage measurement.

Parameters:
- N_BITS, 3, number of state flops and scan-chain length; must be >= 2.
- SEL_W, $clog2(N_BITS), width of the fault-site selector; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- scan_in  input  1  serial scan data into flop 0
- scan_enable  input  1  1 = shift, 0 = functional capture
- inp  input  1  functional FSM input
- fault_load  input  1  strobe: register fault_sel/fault_mode this cycle
- fault_sel  input  SEL_W  target state-bit index
- fault_mode  input  2  00 none, 01 SA0, 10 SA1, 11 single-capture flip
- out  output  1  faulted view of q[N_BITS-1]
- scan_out  output  1  true q[N_BITS-1]; scan chain tail
- fault_active  output  1  1 while registered mode != 00

Behaviour:
- Reset (rst=0, async): all q = 0; fault_sel_r = 0; fault_mode_r = 00. Outputs: out = 0, scan_out = 0, fault_active = 0.
- Faulted view qf[i]:
  - equals q[i], except at i == fault_sel_r.
  - At that bit: SA0 -> 0; SA1 -> 1; flip -> ~q[i].
  - Combinational, zero latency.
- Functional capture (scan_enable = 0), next state from qf:
  - d[0] = (qf[N-2] & ~inp) | (qf[N-1] & inp)
  - d[i] = qf[i-1] & inp, for 1 <= i <= N-1
- Shift (scan_enable = 1): q[0] <= scan_in; q[i] <= q[i-1]. The shift path uses true q; faults never corrupt shifted data.
- Fault register:
  - On fault_load = 1: fault_sel_r <= fault_sel and fault_mode_r <= fault_mode. Active from the next cycle.
  - If fault_sel >= N_BITS on load: fault_mode_r <= 00 (load rejected as no-fault).
- Flip mode:
  - Applies to exactly one functional capture edge; on that edge fault_mode_r <= 00.
  - During shift cycles the flip stays pending. qf is still flipped combinationally on out.
  - fault_load and flip consumption on the same edge: load wins.
- Static SA modes persist until reloaded or reset.
- Reset mid-shift or mid-capture: immediate clear of all state and fault registers. No partial update survives.
- fault_active = (fault_mode_r != 00), registered-derived.

Optional Feature:
- FAULT_INJECT_EN
  - Defined: fault register, qf mux, fault_active as above.
  - Undefined: no fault logic is synthesised; qf = q; fault_active tied 0; fault_load/fault_sel/fault_mode ignored. Ports remain.

Decomposition:
- Package fsm_fi_pkg:
  - fault_mode_e enum (FM_NONE=00, FM_SA0=01, FM_SA1=10, FM_FLIP=11)
  - default N_BITS constant
- Sub-module: the existing scan_dff (clk, rst, scan_in, scan_enable, d, q), active-low async reset, instantiated N_BITS times via generate.
- Fault mux and register stay inline.

Test Plan:
- Reset/idle: rst=0 with any inputs, N=3 -> q=000, out=0, scan_out=0, fault_active=0; deassert with scan_enable=0, inp=0 -> q stays 000.
- Scan shift: scan_enable=1, scan_in 1,0,0 over 3 cycles -> q{2,1,0}=100, out=1, scan_out=1. Shift 3 more zeros -> scan_out sequence 1,0,0 observed.
- Fault-free capture:
  - Scan in q=010, inp=0, one capture -> q=001.
  - Rescan q=010, inp=1 -> q=100.
- SA0 at bit 1:
  - Load sel=1, mode=01; scan q=010, inp=0, capture -> q=000 (good machine 001).
  - Repeat with inp=1 -> q=000 (good machine 100). fault_active=1 throughout.
- SA1 at bit 2:
  - Load sel=2, mode=10 with q=000 -> out=1 next cycle, scan_out=0.
  - inp=1 capture -> q=001.
- Flip and edge cases:
  - Load sel=0, mode=11; scan q=001 over 3 shift cycles -> fault_active stays 1.
  - Capture inp=1 -> q=000 (good 010); next cycle fault_active=0.
  - Load sel=3 (N=3) -> fault_active=0.
  - Build without FAULT_INJECT_EN -> SA0 scenario yields good-machine 001.
